// File: rtl/digit_capture.sv
// rtl/digit_capture.sv - captures a multiplexed 4-digit segment bus into a registered frame
//
// Ports:
//   clk_100Hz  in   sample clock, all state updates on its rising edge
//   rst        in   asynchronous active-high reset
//   seg_in     in   [7:0] segment bus, active-low, sampled on a valid strobe
//   anodes_in  in   [3:0] digit strobes, active-low, one low bit = digit index
//   digit0..3  out  [7:0] last complete committed frame
//   frame_valid out locked and at least one frame committed
//   frame_done out  one-cycle pulse on each frame commit
//   seq_err    out  one-cycle pulse on a strobe sequence violation
//   err_count  out  [7:0] saturating count of seq_err pulses

module digit_capture #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic       clk_100Hz,
    input  logic       rst,
    input  logic [7:0] seg_in,
    input  logic [3:0] anodes_in,
    output logic [7:0] digit0,
    output logic [7:0] digit1,
    output logic [7:0] digit2,
    output logic [7:0] digit3,
    output logic       frame_valid,
    output logic       frame_done,
    output logic       seq_err,
    output logic [7:0] err_count
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic {
        HUNT,
        CAPTURE
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] expect_q, expect_d;
    logic [7:0] idle_q, idle_d;
    logic [7:0] shadow_q [4];
    logic [7:0] shadow_d [4];
    logic [7:0] digit_q [4];
    logic [7:0] digit_d [4];
    logic       fv_q, fv_d;
    logic       fd_q, fd_d;
    logic       se_q, se_d;
    logic [7:0] ec_q, ec_d;

    // Strobe classification: active-high view of the anodes.
    logic [3:0] strobe;
    logic       is_idle;
    logic       is_valid;
    logic       is_multi;
    logic [1:0] idx;

    assign strobe = ~anodes_in;

    always_comb begin
        is_idle  = (strobe == 4'd0);
        // Power-of-two test: exactly one bit set.
        is_valid = !is_idle && ((strobe & (strobe - 4'd1)) == 4'd0);
        is_multi = !is_idle && !is_valid;
        case (strobe)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        expect_d = expect_q;
        idle_d   = idle_q;
        shadow_d = shadow_q;
        digit_d  = digit_q;
        fv_d     = fv_q;
        fd_d     = 1'b0;
        se_d     = 1'b0;

        case (state_q)
            HUNT: begin
                idle_d = 8'd0;
                if (is_valid && idx == 2'd0) begin
                    shadow_d[0] = seg_in;
                    expect_d    = 2'd1;
                    state_d     = CAPTURE;
                end else if (is_multi) begin
                    se_d = 1'b1;
                end
            end
            CAPTURE: begin
                if (is_valid && idx == expect_q) begin
                    idle_d        = 8'd0;
                    shadow_d[idx] = seg_in;
                    expect_d      = expect_q + 2'd1;
                    if (idx == 2'd3) begin
                        // Commit uses the incoming byte directly so all four
                        // digits update on the edge that samples digit 3.
                        digit_d[0] = shadow_q[0];
                        digit_d[1] = shadow_q[1];
                        digit_d[2] = shadow_q[2];
                        digit_d[3] = seg_in;
                        fd_d       = 1'b1;
                        fv_d       = 1'b1;
                    end
                end else if (is_valid || is_multi) begin
                    se_d     = 1'b1;
                    fv_d     = 1'b0;
                    idle_d   = 8'd0;
                    shadow_d = '{default: 8'hFF};
                    expect_d = 2'd0;
                    state_d  = HUNT;
                    // An out-of-order index 0 is also a valid frame start.
                    if (is_valid && idx == 2'd0) begin
                        shadow_d[0] = seg_in;
                        expect_d    = 2'd1;
                        state_d     = CAPTURE;
                    end
                end else begin
                    if (idle_q == TIMEOUT_C - 8'd1) begin
                        idle_d   = 8'd0;
                        fv_d     = 1'b0;
                        shadow_d = '{default: 8'hFF};
                        expect_d = 2'd0;
                        state_d  = HUNT;
                    end else begin
                        idle_d = idle_q + 8'd1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        ec_d = ec_q;
        if (se_d && ec_q != 8'hFF) begin
            ec_d = ec_q + 8'd1;
        end
    end

    always_ff @(posedge clk_100Hz or posedge rst) begin
        if (rst) begin
            state_q  <= HUNT;
            expect_q <= 2'd0;
            idle_q   <= 8'd0;
            shadow_q <= '{default: 8'hFF};
            digit_q  <= '{default: 8'hFF};
            fv_q     <= 1'b0;
            fd_q     <= 1'b0;
            se_q     <= 1'b0;
            ec_q     <= 8'd0;
        end else begin
            state_q  <= state_d;
            expect_q <= expect_d;
            idle_q   <= idle_d;
            shadow_q <= shadow_d;
            digit_q  <= digit_d;
            fv_q     <= fv_d;
            fd_q     <= fd_d;
            se_q     <= se_d;
            ec_q     <= ec_d;
        end
    end

    assign digit0      = digit_q[0];
    assign digit1      = digit_q[1];
    assign digit2      = digit_q[2];
    assign digit3      = digit_q[3];
    assign frame_valid = fv_q;
    assign frame_done  = fd_q;
    assign seq_err     = se_q;
    assign err_count   = ec_q;

endmodule

// File: tb/tb_digit_capture.sv
// tb/tb_digit_capture.sv - randomized and directed bench for digit_capture

module tb_digit_capture;

    localparam int TMO = 8;

    logic       clk_100Hz = 1'b0;
    logic       rst;
    logic [7:0] seg_in;
    logic [3:0] anodes_in;
    logic [7:0] digit0, digit1, digit2, digit3;
    logic       frame_valid, frame_done, seq_err;
    logic [7:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;

    digit_capture #(.TIMEOUT(TMO)) dut (
        .clk_100Hz  (clk_100Hz),
        .rst        (rst),
        .seg_in     (seg_in),
        .anodes_in  (anodes_in),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .frame_valid(frame_valid),
        .frame_done (frame_done),
        .seq_err    (seq_err),
        .err_count  (err_count)
    );

    always #5 clk_100Hz = ~clk_100Hz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: "locked" with a next-digit cursor, a partial frame and
    // the shown frame, driven directly from the strobe rules.
    bit          m_locked;
    int          m_next;
    int          m_idle;
    logic [7:0]  m_part [4];
    logic [7:0]  m_dig  [4];
    bit          m_fv, m_fd, m_se;
    int          m_ec;

    task automatic model_reset();
        m_locked = 0; m_next = 0; m_idle = 0;
        m_part = '{default: 8'hFF};
        m_dig  = '{default: 8'hFF};
        m_fv = 0; m_fd = 0; m_se = 0; m_ec = 0;
    endtask

    task automatic model_step(input logic [3:0] a, input logic [7:0] s);
        int zeros;
        int pos;
        zeros = 0;
        pos   = 0;
        for (int i = 0; i < 4; i++) begin
            if (a[i] == 1'b0) begin
                zeros++;
                pos = i;
            end
        end
        m_fd = 0;
        m_se = 0;
        if (!m_locked) begin
            m_idle = 0;
            if (zeros == 1 && pos == 0) begin
                m_part[0] = s; m_next = 1; m_locked = 1;
            end else if (zeros >= 2) begin
                m_se = 1;
            end
        end else if (zeros == 1) begin
            m_idle = 0;
            if (pos == m_next) begin
                m_part[pos] = s;
                m_next = (m_next + 1) % 4;
                if (pos == 3) begin
                    m_dig = m_part;
                    m_fd = 1;
                    m_fv = 1;
                end
            end else begin
                m_se = 1; m_fv = 0; m_locked = 0;
                if (pos == 0) begin
                    m_part[0] = s; m_next = 1; m_locked = 1;
                end
            end
        end else if (zeros == 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_locked = 0; m_fv = 0; m_idle = 0;
            end
        end else begin
            m_se = 1; m_fv = 0; m_locked = 0; m_idle = 0;
        end
        if (m_se && m_ec < 255) m_ec++;
    endtask

    task automatic compare_all();
        check("digits", {digit0, digit1, digit2, digit3}, {m_dig[0], m_dig[1], m_dig[2], m_dig[3]});
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("seq_err", 32'(seq_err), 32'(m_se));
        check("err_count", 32'(err_count), 32'(m_ec));
        check("done_err_excl", 32'(frame_done & seq_err), 32'd0);
    endtask

    // Inputs are driven 1 time unit after a rising edge and outputs are
    // checked 1 time unit after the next one.
    task automatic step(input logic [3:0] a, input logic [7:0] s);
        anodes_in = a;
        seg_in    = s;
        @(posedge clk_100Hz);
        model_step(a, s);
        #1;
        compare_all();
    endtask

    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk_100Hz);
        #1;
        rst = 1'b0;
        compare_all();
    endtask

    task automatic frame(input logic [31:0] v);
        step(4'b1110, v[31:24]);
        step(4'b1101, v[23:16]);
        step(4'b1011, v[15:8]);
        step(4'b0111, v[7:0]);
    endtask

    logic [3:0] multi_tab [6];

    initial begin
        multi_tab = '{4'b1100, 4'b1010, 4'b0000, 4'b0101, 4'b0011, 4'b1001};
        rst = 1'b1;
        anodes_in = 4'hF;
        seg_in = 8'h00;
        model_reset();
        #3;
        compare_all();
        check("reset_digits", {digit0, digit1, digit2, digit3}, 32'hFFFF_FFFF);
        @(posedge clk_100Hz);
        #1;
        rst = 1'b0;

        // Basic frame after reset.
        frame(32'hC0F9_A4B0);
        check("basic_done", 32'(frame_done), 32'd1);
        check("basic_digits", {digit0, digit1, digit2, digit3}, 32'hC0F9_A4B0);
        check("basic_valid", 32'(frame_valid), 32'd1);

        // Skip from 1 to 3.
        step(4'b1110, 8'h11);
        step(4'b1101, 8'h22);
        step(4'b0111, 8'h33);
        check("skip_err", 32'(seq_err), 32'd1);
        check("skip_valid", 32'(frame_valid), 32'd0);
        check("skip_count", 32'(err_count), 32'd1);
        check("skip_hold", {digit0, digit1, digit2, digit3}, 32'hC0F9_A4B0);

        // Reset between digit 2 and 3; the trailing digit-3 strobe is ignored.
        step(4'b1110, 8'h01);
        step(4'b1101, 8'h02);
        step(4'b1011, 8'h03);
        pulse_reset();
        step(4'b0111, 8'h04);
        check("rst_ignore", 32'(frame_done | frame_valid), 32'd0);
        frame(32'h1234_5678);
        check("rst_commit", {digit0, digit1, digit2, digit3}, 32'h1234_5678);

        // Stream entered at index 2.
        pulse_reset();
        step(4'b1011, 8'hAA);
        step(4'b0111, 8'hBB);
        step(4'b1110, 8'h5A);
        step(4'b1101, 8'h6B);
        step(4'b1011, 8'h7C);
        check("mid_no_done", 32'(frame_done), 32'd0);
        step(4'b0111, 8'h8D);
        check("mid_done", 32'(frame_done), 32'd1);
        check("mid_digit0", 32'(digit0), 32'h5A);
        check("mid_errs", 32'(err_count), 32'd0);

        // Idle tolerance and timeout.
        for (int i = 0; i < TMO - 1; i++) step(4'b1111, 8'h00);
        check("idle7_valid", 32'(frame_valid), 32'd1);
        frame(32'h0102_0304);
        check("idle7_commit", 32'(frame_done), 32'd1);
        for (int i = 0; i < TMO - 1; i++) step(4'b1111, 8'h00);
        check("idle_pre_tmo", 32'(frame_valid), 32'd1);
        step(4'b1111, 8'h00);
        check("idle_tmo", 32'(frame_valid), 32'd0);
        check("idle_tmo_err", 32'(seq_err), 32'd0);

        // Multi-strobe violations and saturation.
        frame(32'h9988_7766);
        step(4'b1100, 8'h00);
        check("multi_err", 32'(seq_err), 32'd1);
        check("multi_valid", 32'(frame_valid), 32'd0);
        for (int i = 0; i < 259; i++) step(4'b1100, 8'h00);
        check("err_sat", 32'(err_count), 32'd255);

        // Randomized traffic.
        begin
            int cur;
            cur = 0;
            for (int n = 0; n < 3000; n++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r < 65) begin
                    step(~(4'b0001 << cur), 8'($urandom));
                    cur = (cur + 1) % 4;
                end else if (r < 75) begin
                    step(4'b1111, 8'($urandom));
                end else if (r < 80) begin
                    int k;
                    k = int'($urandom_range(5, 10));
                    for (int j = 0; j < k; j++) step(4'b1111, 8'($urandom));
                end else if (r < 88) begin
                    step(~(4'b0001 << $urandom_range(0, 3)), 8'($urandom));
                end else if (r < 93) begin
                    step(multi_tab[$urandom_range(0, 5)], 8'($urandom));
                end else if (r < 95) begin
                    pulse_reset();
                    cur = 0;
                end else begin
                    step(4'($urandom), 8'($urandom));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_capture.md
DIGIT_CAPTURE -- requirements
Module: digit_capture

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8, meaning consecutive idle samples (range 1..255) before sync loss.
REQ-002 clk_100Hz  input  1  sample clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 seg_in  input  8  multiplexed segment bus, active-low, same clock domain as clk_100Hz.
REQ-005 anodes_in  input  4  digit strobes, active-low; exactly one low bit selects digit index 0..3.
REQ-006 digit0..digit3  output  8 each  last complete captured frame, registered.
REQ-007 frame_valid  output  1  high while locked and at least one complete frame has been committed.
REQ-008 frame_done  output  1  one-cycle pulse on each frame commit.
REQ-009 seq_err  output  1  one-cycle pulse on a strobe sequence violation.
REQ-010 err_count  output  8  saturating count of seq_err pulses.

Function
REQ-011 Each rising edge SHALL classify anodes_in: VALID (exactly one bit low, index = position of the low bit), IDLE (4'b1111), or MULTI (two or more bits low).
REQ-012 The FSM SHALL have two states: HUNT and CAPTURE; the reset state SHALL be HUNT.
REQ-013 HUNT: VALID index 0 -> store seg_in into shadow[0], expect <= 1, go to CAPTURE; any other VALID index or IDLE -> stay in HUNT, no error; MULTI -> seq_err pulse, stay in HUNT.
REQ-014 CAPTURE: VALID with index == expect -> store seg_in into shadow[index], expect <= expect+1 mod 4, idle counter cleared.
REQ-015 CAPTURE: VALID with index == 3 in sequence -> shadow[0..2] and seg_in SHALL be copied to digit0..digit3 atomically on the same edge, frame_done = 1 for that single cycle, frame_valid <= 1, stay in CAPTURE with expect = 0.
REQ-016 Commit latency SHALL be one edge: digit outputs and frame_done change on the edge that samples digit 3.
REQ-017 CAPTURE: VALID with index != expect, or MULTI -> seq_err pulse, frame_valid <= 0, go to HUNT, and shadow contents are discarded; digit0..3 SHALL hold their last committed values.
REQ-018 A re-sync SHALL start on the same edge when the violating strobe is VALID index 0: shadow[0] is loaded, expect <= 1, state is CAPTURE.
REQ-019 CAPTURE: IDLE -> idle counter +1, expect and shadow unchanged; when the counter reaches TIMEOUT -> go to HUNT, frame_valid <= 0, counter cleared, no seq_err.
REQ-020 The idle counter SHALL be 8 bits, cleared by any VALID sample and in HUNT.
REQ-021 err_count SHALL increment by 1 on each seq_err pulse and saturate at 255.
REQ-022 frame_done and seq_err SHALL never both be high in the same cycle.
REQ-023 seg_in SHALL be ignored on IDLE and MULTI samples.

Reset
REQ-024 While rst is high: state = HUNT, expect = 0, idle counter = 0, shadow[0..3] = 8'hFF, digit0..3 = 8'hFF (blank), frame_valid = 0, frame_done = 0, seq_err = 0, err_count = 0.
REQ-025 An rst assertion mid-frame SHALL discard the partial frame; after release, capture SHALL resume only from the next index-0 strobe.

Verification
REQ-026 Strobes 1110/C0, 1101/F9, 1011/A4, 0111/B0 after reset -> frame_done on the 4th edge; digit0..3 = C0,F9,A4,B0; frame_valid = 1; seq_err = 0.
REQ-027 Start stream at index 2 (1011, 0111, 1110, 1101, 1011, 0111) -> no seq_err; first commit on the 6th edge with digit0 = value sampled on edge 3.
REQ-028 Locked, then indices 0,1,3 -> seq_err pulse on edge 3, frame_valid = 0, err_count = 1, digit outputs unchanged from the prior frame.
REQ-029 Locked, then anodes_in = 1100 -> seq_err pulse, state = HUNT; 256 such violations -> err_count = 255 held.
REQ-030 TIMEOUT=8, locked, then 8 IDLE samples -> frame_valid falls on the 8th edge with no seq_err; 7 IDLE samples then index at expect -> capture continues and the frame commits normally.
REQ-031 rst pulsed between digit 2 and digit 3 -> all outputs = reset values; the following 0111 strobe is ignored; the next full 0-1-2-3 sequence commits.
